// File: rtl/psum_accumulator_if.sv
`default_nettype none
// ============================================================================
// Module  : psum_accumulator_if
// Brief   : Product-in / drain-out handshake bundle for psum_accumulator.
// Rev     : 1.0  initial release
// ============================================================================
interface psum_accumulator_if #(
  parameter int PSUM_BW = 16,
  parameter int COL     = 4,
  parameter int IDX_BW  = $clog2(COL)
);
  logic               in_valid;
  logic               in_ready;
  logic [PSUM_BW-1:0] in_psum;
  logic [IDX_BW-1:0]  in_index;
  logic               in_last;

  logic               out_valid;
  logic               out_ready;
  logic [PSUM_BW-1:0] out_psum;
  logic [IDX_BW-1:0]  out_col;
  logic               out_last;

  modport master (
    output in_valid, in_psum, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_psum, out_col, out_last
  );

  modport slave (
    input  in_valid, in_psum, in_index, in_last, out_ready,
    output in_ready, out_valid, out_psum, out_col, out_last
  );
endinterface
`default_nettype wire

// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
// Module  : psum_accumulator
// Brief   : Per-column partial-sum buffers fed by the MAC tile, drained on
//           end-of-tile. Optional macro PSUM_SATURATE_EN: saturating adds
//           plus a sticky sat_flag output.
// Rev     : 1.0  initial release
// ============================================================================
module psum_accumulator #(
  parameter int PSUM_BW = 16,
  parameter int COL     = 4,
  parameter int IDX_BW  = $clog2(COL)
) (
  input  logic              clk,
  input  logic              reset,
  psum_accumulator_if.slave bus,
  output logic              busy
`ifdef PSUM_SATURATE_EN
  ,
  output logic              sat_flag
`endif
);

  typedef enum logic [0:0] {
    ST_ACC   = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [PSUM_BW-1:0] r_buf [COL];
  logic [IDX_BW-1:0]  r_drain_ptr;
  logic               w_in_fire;
  logic               w_out_fire;
  logic               w_ptr_last;
  logic [PSUM_BW-1:0] w_sum;

  assign w_ptr_last = (r_drain_ptr == IDX_BW'(COL - 1));
  assign w_in_fire  = (r_state == ST_ACC) && bus.in_valid;
  assign w_out_fire = (r_state == ST_DRAIN) && bus.out_ready;

`ifdef PSUM_SATURATE_EN
  logic [PSUM_BW:0]   w_sum_ext;
  logic               w_sum_sat;
  logic               r_sat_flag;

  assign w_sum_ext = {1'b0, r_buf[bus.in_index]} + {1'b0, bus.in_psum};
  assign w_sum_sat = w_sum_ext[PSUM_BW];
  assign w_sum     = w_sum_sat ? '1 : w_sum_ext[PSUM_BW-1:0];
  assign sat_flag  = r_sat_flag;

  // Sticky per tile: cleared once the tile's last word has been handed off.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_flag <= 1'b0;
    end else if (w_out_fire && w_ptr_last) begin
      r_sat_flag <= 1'b0;
    end else if (w_in_fire && w_sum_sat) begin
      r_sat_flag <= 1'b1;
    end
  end
`else
  assign w_sum = r_buf[bus.in_index] + bus.in_psum;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_ACC;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    busy          = 1'b0;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_psum  = '0;
    bus.out_col   = '0;
    bus.out_last  = 1'b0;
    case (r_state)
      ST_ACC: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid && bus.in_last) begin
          w_next_state = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy          = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_psum  = r_buf[r_drain_ptr];
        bus.out_col   = r_drain_ptr;
        bus.out_last  = w_ptr_last;
        if (bus.out_ready && w_ptr_last) begin
          w_next_state = ST_ACC;
        end
      end
      default: w_next_state = ST_ACC;
    endcase
  end

  // Accumulate and drain-clear never coincide: they belong to different states.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < COL; i++) begin
        r_buf[i] <= '0;
      end
      r_drain_ptr <= '0;
    end else begin
      if (w_in_fire) begin
        r_buf[bus.in_index] <= w_sum;
      end
      if (w_out_fire) begin
        r_buf[r_drain_ptr] <= '0;
        r_drain_ptr        <= r_drain_ptr + IDX_BW'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Downstream of the sparse MAC tile. Consumes its registered product stream (out_psum plus w_index_out) and accumulates each product into one of col per-output-column partial-sum buffers.
- On an end-of-tile marker it drains the col buffers over a valid/ready handshake toward the output SRAM/ofifo, then clears them for the next tile.

Parameters:
- psum_bw, 16, width of incoming products and of each accumulator buffer
- col, 4, number of output columns / accumulator buffers; must be a power of two, at least 2
- idx_bw, $clog2(col), width of column index

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  product beat valid (driven from the MAC tile's registered execute)
- in_ready  output  1  block can accept a beat
- in_psum  input  psum_bw  unsigned product from the MAC tile
- in_index  input  idx_bw  target column (MAC tile w_index_out)
- in_last  input  1  qualifies the final beat of a tile
- out_valid  output  1  drain word valid
- out_ready  input  1  downstream accepts drain word
- out_psum  output  psum_bw  drained accumulator value
- out_col  output  idx_bw  column of out_psum
- out_last  output  1  high with the word for column col-1
- busy  output  1  high in DRAIN state

Behaviour:
- Single clock; all state is updated on posedge clk; reset is synchronous and active-high.
- Reset:
  - state=ACC; all buffers=0; drain_ptr=0.
  - out_valid=0, out_psum=0, out_col=0, out_last=0, busy=0; in_ready=1 in the cycle after reset deasserts.
- State ACC:
  - in_ready=1, out_valid=0.
  - A beat is accepted when in_valid & in_ready. Then buf[in_index] <= buf[in_index] + in_psum, with psum_bw wrap, unsigned arithmetic.
  - An accepted beat with in_last=1 is accumulated like any other beat, and state becomes DRAIN on the same edge.
  - in_last without in_valid is ignored.
- State DRAIN:
  - in_ready=0; in_valid is ignored and no buffer changes except clears.
  - out_valid=1, out_psum=buf[drain_ptr], out_col=drain_ptr, out_last=(drain_ptr==col-1). These outputs are combinational from registers, so the first word is visible in the first DRAIN cycle.
  - Handshake: a word transfers when out_valid & out_ready. On transfer, buf[drain_ptr] <= 0 and drain_ptr increments.
  - While out_ready=0, all out_* hold stable. out_valid never drops without a transfer.
  - On transfer of the col-1 word: drain_ptr wraps to 0 and state returns to ACC. in_ready=1 on the next cycle.
- Latency:
  - Last beat accepted at edge N; first drain word is valid in the cycle after edge N.
  - With out_ready held at 1, a drain takes exactly col cycles, and the block is back in ACC at edge N+col.
- Boundary conditions:
  - A tile with zero beats never enters DRAIN, since in_last must be carried on a valid beat.
  - Repeated beats to the same column in consecutive cycles must accumulate correctly (read-modify-write, no hazard).
  - reset mid-DRAIN: abort immediately, clear all buffers, return to ACC; undelivered words are lost.
  - reset has priority over a simultaneous handshake.

Optional Feature:
- Macro: PSUM_SATURATE_EN.
- Defined: each accumulate saturates at 2^psum_bw-1 instead of wrapping. A sticky sat_flag output (1 bit, cleared by reset and on the out_last transfer) goes high when any add in the current tile saturated.
- Undefined: modulo 2^psum_bw wrap as above; sat_flag port does not exist.

Test Plan:
- Basic tile:
  - Stimulus: after reset, beats (idx,psum) = (0,5),(1,3),(0,7),(3,9 last), out_ready=1.
  - Response: drain words col0=12, col1=3, col2=0, col3=9 with out_last on col3. busy high for 4 cycles, then in_ready=1.
- Back-pressure:
  - Stimulus: same tile; out_ready=0 for 3 cycles on col1, then 1.
  - Response: out_psum=3 and out_col=1 held stable throughout the stall; no word skipped or duplicated.
- Same-column hazard:
  - Stimulus: 4 consecutive beats to col2 of value 15, the last with in_last.
  - Response: col2 drains as 60.
- Wrap/saturate:
  - Stimulus: beats 0xFFF0 and 0x0020 to col0, the second with in_last.
  - Response: 0x0010 without the macro. With PSUM_SATURATE_EN: 0xFFFF and sat_flag=1.
- Input ignored in DRAIN:
  - Stimulus: in_valid=1 held during drain with psum=100.
  - Response: in_ready=0, and the next tile starts from zeroed buffers.
- Reset mid-drain:
  - Stimulus: assert reset after col0 transfers.
  - Response: out_valid=0 the next cycle; a new tile with a single beat (1,4 last) drains 0,4,0,0.
